// File: rtl/exe_mem_stage.sv
// EX/MEM pipeline register with the architectural NZCV status register,
// flag forwarding to the decode-stage condition check, and carry feedback.
module exe_mem_stage #(
  parameter int DATA_W = 32,
  parameter int REG_AW = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              stall,
  input  logic              flush,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] alu_result,
  input  logic [3:0]        status_in,
  input  logic              s_update,
  input  logic [DATA_W-1:0] store_val,
  input  logic [REG_AW-1:0] dest_in,
  input  logic              wb_en_in,
  input  logic              mem_r_en_in,
  input  logic              mem_w_en_in,
  input  logic [3:0]        cond,
  output logic              out_valid,
  output logic [DATA_W-1:0] alu_result_out,
  output logic [DATA_W-1:0] store_val_out,
  output logic [REG_AW-1:0] dest_out,
  output logic              wb_en_out,
  output logic              mem_r_en_out,
  output logic              mem_w_en_out,
  output logic [3:0]        status_reg,
  output logic              carry_flag,
  output logic              cond_pass
);

  logic              valid_q, valid_d;
  logic [DATA_W-1:0] result_q, result_d;
  logic [DATA_W-1:0] store_q, store_d;
  logic [REG_AW-1:0] dest_q, dest_d;
  logic              wb_en_q, wb_en_d;
  logic              mem_r_q, mem_r_d;
  logic              mem_w_q, mem_w_d;
  logic [3:0]        status_q, status_d;

  logic              advance;
  logic              flag_write;
  logic [3:0]        fwd_flags;
  logic              f_n, f_z, f_c, f_v;

  assign advance    = !flush && !stall;
  assign flag_write = advance && in_valid && s_update;

  always_comb begin
    valid_d  = valid_q;
    result_d = result_q;
    store_d  = store_q;
    dest_d   = dest_q;
    wb_en_d  = wb_en_q;
    mem_r_d  = mem_r_q;
    mem_w_d  = mem_w_q;
    status_d = status_q;
    if (flush) begin
      // Squash only the control bits; the data fields simply hold.
      valid_d = 1'b0;
      wb_en_d = 1'b0;
      mem_r_d = 1'b0;
      mem_w_d = 1'b0;
    end else if (!stall) begin
      valid_d  = in_valid;
      result_d = alu_result;
      store_d  = store_val;
      dest_d   = dest_in;
      wb_en_d  = wb_en_in && in_valid;
      mem_r_d  = mem_r_en_in && in_valid;
      mem_w_d  = mem_w_en_in && in_valid;
      if (flag_write) begin
        status_d = status_in;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q  <= 1'b0;
      result_q <= '0;
      store_q  <= '0;
      dest_q   <= '0;
      wb_en_q  <= 1'b0;
      mem_r_q  <= 1'b0;
      mem_w_q  <= 1'b0;
      status_q <= 4'b0000;
    end else begin
      valid_q  <= valid_d;
      result_q <= result_d;
      store_q  <= store_d;
      dest_q   <= dest_d;
      wb_en_q  <= wb_en_d;
      mem_r_q  <= mem_r_d;
      mem_w_q  <= mem_w_d;
      status_q <= status_d;
    end
  end

  // A flag producer in EX resolves the condition of the instruction in decode without a bubble.
  assign fwd_flags = flag_write ? status_in : status_q;
  assign f_n = fwd_flags[3];
  assign f_z = fwd_flags[2];
  assign f_c = fwd_flags[1];
  assign f_v = fwd_flags[0];

  always_comb begin
    cond_pass = 1'b0;
    case (cond)
      4'b0000: cond_pass = f_z;
      4'b0001: cond_pass = !f_z;
      4'b0010: cond_pass = f_c;
      4'b0011: cond_pass = !f_c;
      4'b0100: cond_pass = f_n;
      4'b0101: cond_pass = !f_n;
      4'b0110: cond_pass = f_v;
      4'b0111: cond_pass = !f_v;
      4'b1000: cond_pass = f_c && !f_z;
      4'b1001: cond_pass = !f_c || f_z;
      4'b1010: cond_pass = (f_n == f_v);
      4'b1011: cond_pass = (f_n != f_v);
      4'b1100: cond_pass = !f_z && (f_n == f_v);
      4'b1101: cond_pass = f_z || (f_n != f_v);
      4'b1110: cond_pass = 1'b1;
      default: cond_pass = 1'b0;
    endcase
  end

  assign out_valid      = valid_q;
  assign alu_result_out = result_q;
  assign store_val_out  = store_q;
  assign dest_out       = dest_q;
  assign wb_en_out      = wb_en_q;
  assign mem_r_en_out   = mem_r_q;
  assign mem_w_en_out   = mem_w_q;
  assign status_reg     = status_q;
  // Carry is deliberately taken from the committed flags, not the forwarded ones.
  assign carry_flag     = status_q[1];

endmodule

// File: tb/tb_exe_mem_stage.sv
// Randomized and directed check of exe_mem_stage against a behavioural model
// of the pipeline register, status register and condition table.
module tb_exe_mem_stage;

  localparam int DW = 32;
  localparam int AW = 4;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          stall, flush, in_valid, s_update;
  logic [DW-1:0] alu_result, store_val;
  logic [3:0]    status_in, cond;
  logic [AW-1:0] dest_in;
  logic          wb_en_in, mem_r_en_in, mem_w_en_in;
  logic          out_valid, wb_en_out, mem_r_en_out, mem_w_en_out;
  logic [DW-1:0] alu_result_out, store_val_out;
  logic [AW-1:0] dest_out;
  logic [3:0]    status_reg;
  logic          carry_flag, cond_pass;

  exe_mem_stage #(.DATA_W(DW), .REG_AW(AW)) dut (
    .clk(clk), .rst_n(rst_n), .stall(stall), .flush(flush),
    .in_valid(in_valid), .alu_result(alu_result), .status_in(status_in),
    .s_update(s_update), .store_val(store_val), .dest_in(dest_in),
    .wb_en_in(wb_en_in), .mem_r_en_in(mem_r_en_in), .mem_w_en_in(mem_w_en_in),
    .cond(cond), .out_valid(out_valid), .alu_result_out(alu_result_out),
    .store_val_out(store_val_out), .dest_out(dest_out), .wb_en_out(wb_en_out),
    .mem_r_en_out(mem_r_en_out), .mem_w_en_out(mem_w_en_out),
    .status_reg(status_reg), .carry_flag(carry_flag), .cond_pass(cond_pass)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_passed = 0;

  // Reference state: what the stage should be holding.
  logic          m_valid, m_wb, m_mr, m_mw;
  logic [DW-1:0] m_result, m_store;
  logic [AW-1:0] m_dest;
  logic [3:0]    m_status;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_passed++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
  endtask

  // Condition rules, evaluated from named flags.
  function automatic logic ref_cond(input logic [3:0] c, input logic [3:0] f);
    logic n, z, cy, v;
    {n, z, cy, v} = f;
    case (c)
      0: return z;            1: return !z;
      2: return cy;           3: return !cy;
      4: return n;            5: return !n;
      6: return v;            7: return !v;
      8: return cy & !z;      9: return !cy | z;
      10: return n == v;      11: return n != v;
      12: return !z & (n == v); 13: return z | (n != v);
      14: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  function automatic logic [3:0] ref_flags();
    if (in_valid && s_update && !stall && !flush) return status_in;
    return m_status;
  endfunction

  task automatic model_reset();
    m_valid = 0; m_wb = 0; m_mr = 0; m_mw = 0;
    m_result = '0; m_store = '0; m_dest = '0; m_status = 4'b0000;
  endtask

  task automatic model_clock();
    if (flush) begin
      m_valid = 0; m_wb = 0; m_mr = 0; m_mw = 0;
    end else if (!stall) begin
      m_valid  = in_valid;
      m_wb     = wb_en_in & in_valid;
      m_mr     = mem_r_en_in & in_valid;
      m_mw     = mem_w_en_in & in_valid;
      m_result = alu_result;
      m_store  = store_val;
      m_dest   = dest_in;
      if (in_valid && s_update) m_status = status_in;
    end
  endtask

  // Data fields are don't-care when the stage holds a squashed entry after flush;
  // they are only compared when out_valid is expected high.
  task automatic check_outputs(input string tag);
    check({tag, ".valid"}, out_valid, m_valid);
    check({tag, ".wb"}, wb_en_out, m_wb);
    check({tag, ".mr"}, mem_r_en_out, m_mr);
    check({tag, ".mw"}, mem_w_en_out, m_mw);
    check({tag, ".status"}, status_reg, m_status);
    check({tag, ".carry"}, carry_flag, m_status[1]);
    if (m_valid) begin
      check({tag, ".result"}, alu_result_out, m_result);
      check({tag, ".store"}, store_val_out, m_store);
      check({tag, ".dest"}, dest_out, m_dest);
    end
  endtask

  task automatic idle_inputs();
    stall = 0; flush = 0; in_valid = 0; s_update = 0;
    alu_result = '0; store_val = '0; status_in = 4'b0000; cond = 4'b0000;
    dest_in = '0; wb_en_in = 0; mem_r_en_in = 0; mem_w_en_in = 0;
  endtask

  // Called with inputs already applied just after a falling edge.
  task automatic step(input string tag);
    #1;
    check({tag, ".cond_pass"}, cond_pass, ref_cond(cond, ref_flags()));
    @(posedge clk);
    model_clock();
    #1;
    check_outputs(tag);
    @(negedge clk);
  endtask

  task automatic randomize_inputs();
    stall       = ($urandom_range(0, 4) == 0);
    flush       = ($urandom_range(0, 6) == 0);
    in_valid    = ($urandom_range(0, 3) != 0);
    s_update    = $urandom_range(0, 1);
    alu_result  = $urandom;
    store_val   = $urandom;
    status_in   = 4'($urandom);
    dest_in     = AW'($urandom);
    wb_en_in    = $urandom_range(0, 1);
    mem_r_en_in = $urandom_range(0, 1);
    mem_w_en_in = $urandom_range(0, 1);
    cond        = 4'($urandom);
  endtask

  logic [3:0] hold_status;
  logic [8:0] sweep_exp [9];
  logic [3:0] sweep_cond [9];

  initial begin
    idle_inputs();
    model_reset();
    rst_n = 1'b0;
    @(negedge clk);
    #1;
    check("reset", out_valid, 0);
    check_outputs("reset");
    cond = 4'b0000; #1; check("reset.eq", cond_pass, 0);
    cond = 4'b0001; #1; check("reset.ne", cond_pass, 1);
    @(negedge clk);
    rst_n = 1'b1;

    // Flag producer; forwarded flags resolve EQ in the same cycle.
    idle_inputs();
    in_valid = 1; alu_result = 32'h0; status_in = 4'b0100; s_update = 1;
    dest_in = 3; wb_en_in = 1; cond = 4'b0000;
    #1; check("fwd.eq", cond_pass, 1);
    step("adv_flags");
    check("adv.dest", dest_out, 3);
    check("adv.status", status_reg, 4'b0100);

    // Stall hold for three cycles while inputs churn.
    idle_inputs();
    in_valid = 1; alu_result = 32'h1234_5678; wb_en_in = 1;
    step("stall_load");
    hold_status = status_reg;
    for (int i = 0; i < 3; i++) begin
      randomize_inputs();
      stall = 1; flush = 0; in_valid = 1; s_update = 1;
      step("stall_hold");
      check("stall.result", alu_result_out, 32'h1234_5678);
      check("stall.status", status_reg, hold_status);
    end
    idle_inputs();
    in_valid = 1; alu_result = 32'hCAFE_0001;
    step("stall_release");
    check("release.result", alu_result_out, 32'hCAFE_0001);

    // Flush beats stall and blocks the flag write.
    idle_inputs();
    stall = 1; flush = 1; in_valid = 1; mem_w_en_in = 1; s_update = 1; status_in = 4'b1111;
    hold_status = status_reg;
    step("flush");
    check("flush.mw", mem_w_en_out, 0);
    check("flush.status", status_reg, hold_status);

    // Invalid instruction neither writes back nor sets flags.
    idle_inputs();
    in_valid = 0; wb_en_in = 1; s_update = 1; status_in = 4'b1010;
    step("invalid");
    check("invalid.status", status_reg, hold_status);

    // Condition sweep with committed flags N=1,V=1.
    idle_inputs();
    in_valid = 1; s_update = 1; status_in = 4'b1001;
    step("sweep_set");
    sweep_cond = '{4'b1010, 4'b1011, 4'b1100, 4'b1101, 4'b0100, 4'b0110, 4'b1000, 4'b1110, 4'b1111};
    sweep_exp  = '{1, 0, 1, 0, 1, 1, 0, 1, 0};
    idle_inputs();
    for (int i = 0; i < 9; i++) begin
      cond = sweep_cond[i];
      #1;
      check($sformatf("sweep.cond%0d", cond), cond_pass, sweep_exp[i][0]);
    end
    check("sweep.carry", carry_flag, 0);
    @(negedge clk);

    // Randomized traffic against the model.
    for (int i = 0; i < 400; i++) begin
      randomize_inputs();
      step($sformatf("rand%0d", i));
    end

    // Reset asserted mid-stall/flush clears without a clock edge.
    randomize_inputs();
    in_valid = 1; step("pre_areset");
    stall = 1; flush = 1;
    #2;
    rst_n = 1'b0;
    #1;
    model_reset();
    check_outputs("areset");
    check("areset.result", alu_result_out, 0);
    check("areset.store", store_val_out, 0);
    check("areset.dest", dest_out, 0);
    @(negedge clk);
    rst_n = 1'b1;
    idle_inputs();
    step("post_areset");

    $display("%0d/%0d checks passed", n_passed, n_checks);
    $finish;
  end

endmodule
